mac_array_seq_ctrl: RTL and testbench

//  Sequencer for one NUM_MAC-lane MAC array performing K-step dot-product accumulation per lane.

---
 rtl/mac_array_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_mac_array_seq_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_seq_ctrl.sv
// Sequencer for a NUM_MAC-lane MAC array: fetches operand vectors, issues them with the running
// accumulator, captures each lane's acc_out after MAC_LAT cycles, and hands the final vector downstream.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | op_ready high, waiting for an operand vector
// WAIT  | issued vector in flight through the array, bubbles on the inputs
// OUT   | result held until downstream accepts it
module mac_array_seq_ctrl #(
  parameter int NUM_MAC   = 4,
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 16,
  parameter int MAC_LAT   = 2,
  parameter int K_WIDTH   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [K_WIDTH-1:0]             k_len,
  output logic                           busy,
  input  logic                           op_valid,
  output logic                           op_ready,
  input  logic [NUM_MAC*IN_WIDTH-1:0]    op_a,
  input  logic [NUM_MAC*IN_WIDTH-1:0]    op_b,
  output logic                           mac_en,
  output logic [NUM_MAC*IN_WIDTH-1:0]    mac_a,
  output logic [NUM_MAC*IN_WIDTH-1:0]    mac_b,
  output logic [NUM_MAC*ACC_WIDTH-1:0]   mac_acc_in,
  input  logic [NUM_MAC*ACC_WIDTH-1:0]   mac_acc_out,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [NUM_MAC*ACC_WIDTH-1:0]   res_data
);

  // Wait counter is 1 in the issue cycle, so the capture cycle is at MAC_LAT+1.
  localparam int CW = $clog2(MAC_LAT + 2);
  localparam logic [CW-1:0] CAP_CNT = CW'(MAC_LAT + 1);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, OUT} state_t;

  state_t                         state, state_nxt;
  logic                           busy_nxt, mac_en_nxt, res_valid_nxt;
  logic [NUM_MAC*IN_WIDTH-1:0]    mac_a_nxt, mac_b_nxt;
  logic [NUM_MAC*ACC_WIDTH-1:0]   mac_acc_in_nxt, res_data_nxt;
  logic [NUM_MAC*ACC_WIDTH-1:0]   acc, acc_nxt;
  logic [K_WIDTH-1:0]             step, step_nxt, k_reg, k_reg_nxt;
  logic [CW-1:0]                  wait_cnt, wait_cnt_nxt;

  assign op_ready = (state == FETCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      mac_en     <= 1'b0;
      res_valid  <= 1'b0;
      mac_a      <= '0;
      mac_b      <= '0;
      mac_acc_in <= '0;
      res_data   <= '0;
      acc        <= '0;
      step       <= '0;
      k_reg      <= '0;
      wait_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      busy       <= busy_nxt;
      mac_en     <= mac_en_nxt;
      res_valid  <= res_valid_nxt;
      mac_a      <= mac_a_nxt;
      mac_b      <= mac_b_nxt;
      mac_acc_in <= mac_acc_in_nxt;
      res_data   <= res_data_nxt;
      acc        <= acc_nxt;
      step       <= step_nxt;
      k_reg      <= k_reg_nxt;
      wait_cnt   <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    busy_nxt       = busy;
    mac_en_nxt     = mac_en;
    res_valid_nxt  = res_valid;
    // Array inputs are zero except in the single issue cycle of each step.
    mac_a_nxt      = '0;
    mac_b_nxt      = '0;
    mac_acc_in_nxt = '0;
    res_data_nxt   = res_data;
    acc_nxt        = acc;
    step_nxt       = step;
    k_reg_nxt      = k_reg;
    wait_cnt_nxt   = wait_cnt;

    case (state)
      IDLE: begin
        if (start) begin
          busy_nxt  = 1'b1;
          k_reg_nxt = k_len;
          if (k_len != '0) begin
            state_nxt  = FETCH;
            step_nxt   = '0;
            acc_nxt    = '0;
            mac_en_nxt = 1'b1;
          end else begin
            state_nxt     = OUT;
            res_data_nxt  = '0;
            res_valid_nxt = 1'b1;
          end
        end
      end

      FETCH: begin
        if (op_valid) begin
          mac_a_nxt      = op_a;
          mac_b_nxt      = op_b;
          mac_acc_in_nxt = acc;
          wait_cnt_nxt   = CW'(1);
          state_nxt      = WAIT;
        end
      end

      WAIT: begin
        wait_cnt_nxt = wait_cnt + CW'(1);
        if (wait_cnt == CAP_CNT) begin
          wait_cnt_nxt = '0;
          acc_nxt      = mac_acc_out;
          if (step == k_reg - K_WIDTH'(1)) begin
            state_nxt     = OUT;
            res_data_nxt  = mac_acc_out;
            res_valid_nxt = 1'b1;
            mac_en_nxt    = 1'b0;
          end else begin
            step_nxt  = step + K_WIDTH'(1);
            state_nxt = FETCH;
          end
        end
      end

      OUT: begin
        if (res_ready) begin
          res_valid_nxt = 1'b0;
          busy_nxt      = 1'b0;
          state_nxt     = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mac_array_seq_ctrl.sv
// Bench for mac_array_seq_ctrl: behavioural MAC array model, directed jobs, and a result
// scoreboard popped by a monitor on every result handshake.
module tb_mac_array_seq_ctrl;
  localparam int MAC_LAT = 2;

  logic        clk = 1'b0;
  logic        rst, start, op_valid, res_ready;
  logic [7:0]  k_len;
  logic        busy, op_ready, mac_en, res_valid;
  logic [31:0] op_a, op_b, mac_a, mac_b;
  logic [63:0] mac_acc_in, mac_acc_out, res_data;

  mac_array_seq_ctrl #(.NUM_MAC(4), .IN_WIDTH(8), .ACC_WIDTH(16), .MAC_LAT(MAC_LAT), .K_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b), .mac_acc_in(mac_acc_in),
    .mac_acc_out(mac_acc_out), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_count = 0;
  int last_hs_cyc = 0;
  int res_rise_cyc = 0;
  logic res_valid_q = 1'b0;
  logic mac_en_seen = 1'b0;
  logic op_ready_seen = 1'b0;
  logic [63:0] exp_q[$];
  logic [31:0] av[4];
  logic [31:0] bv[4];

  // Behavioural array: acc_out = acc_in + a*b per lane, MAC_LAT stages, advancing while enabled.
  logic [63:0] pipe[MAC_LAT];
  assign mac_acc_out = pipe[MAC_LAT-1];

  function automatic logic [63:0] mac_fn(input logic [31:0] a, input logic [31:0] b, input logic [63:0] c);
    logic [63:0] r;
    for (int i = 0; i < 4; i++)
      r[i*16 +: 16] = c[i*16 +: 16] + 16'(a[i*8 +: 8]) * 16'(b[i*8 +: 8]);
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      for (int s = 0; s < MAC_LAT; s++) pipe[s] <= '0;
    end else if (mac_en) begin
      pipe[0] <= mac_fn(mac_a, mac_b, mac_acc_in);
      for (int s = 1; s < MAC_LAT; s++) pipe[s] <= pipe[s-1];
    end
  end

  function automatic logic [31:0] pk8(input int l0, input int l1, input int l2, input int l3);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  function automatic logic [63:0] pk16(input int l0, input int l1, input int l2, input int l3);
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: handshake counting, activity flags and scoreboard pops on result handshakes.
  always @(negedge clk) begin
    if (!rst) begin
      if (op_valid && op_ready) hs_count++;
      if (mac_en) mac_en_seen = 1'b1;
      if (op_ready) op_ready_seen = 1'b1;
      if (res_valid && !res_valid_q) res_rise_cyc = cyc;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", res_data, 64'hx);
        else chk("scoreboard_res_data", res_data, exp_q.pop_front());
      end
    end
    res_valid_q = res_valid;
  end

  task automatic check_all_zero(input string name);
    chk(name, {busy, op_ready, mac_en, res_valid, 32'(mac_a), 32'(mac_b)}, '0);
    chk({name, "_wide"}, mac_acc_in | res_data, '0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("job_done_timeout", 64'(n < 200), 64'd1);
  endtask

  // Starts a k-step job and delivers n_steps operand vectors from av/bv.
  task automatic run_job(input int k, input int n_steps, input int gap_step, input int gap_len,
                         input logic push_exp, input logic [63:0] exp, input logic wait_done);
    int n;
    if (push_exp) exp_q.push_back(exp);
    hs_count = 0;
    @(posedge clk); #1;
    start = 1'b1; k_len = 8'(k);
    op_a = av[0]; op_b = bv[0]; op_valid = (gap_step != 0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int s = 0; s < n_steps; s++) begin
      op_a = av[s]; op_b = bv[s];
      if (s == gap_step) begin
        op_valid = 1'b0;
        repeat (gap_len) begin
          @(negedge clk);
          chk("stall_mac_ab_zero", {mac_a, mac_b}, '0);
        end
        @(posedge clk); #1;
      end
      op_valid = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(op_valid && op_ready) && n < 100);
      chk("op_handshake_timeout", 64'(n < 100), 64'd1);
      last_hs_cyc = cyc;
      @(posedge clk); #1;
      op_valid = 1'b0;
      @(negedge clk);
      chk("op_ready_low_in_wait", 64'(op_ready), 64'd0);
    end
    if (wait_done) wait_idle();
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; k_len = '0; op_valid = 1'b0; res_ready = 1'b1;
    op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset_state");

    // 1: single step, latency from op handshake to res_valid
    av[0] = pk8(1, 2, 3, 4); bv[0] = pk8(5, 5, 5, 5);
    run_job(1, 1, -1, 0, 1'b1, pk16(5, 10, 15, 20), 1'b1);
    chk("t1_res_latency", 64'(res_rise_cyc - last_hs_cyc), 64'(MAC_LAT + 2));
    chk("t1_hs_count", 64'(hs_count), 64'd1);

    // 2: three steps with accumulator feedback
    av[0] = pk8(1, 1, 1, 1); av[1] = pk8(1, 1, 1, 1); av[2] = pk8(1, 1, 1, 1);
    bv[0] = pk8(2, 2, 2, 2); bv[1] = pk8(3, 3, 3, 3); bv[2] = pk8(4, 4, 4, 4);
    run_job(3, 3, -1, 0, 1'b1, pk16(9, 9, 9, 9), 1'b1);
    chk("t2_hs_count", 64'(hs_count), 64'd3);

    // 3: operand stall mid-job leaves the result unchanged
    run_job(3, 3, 1, 5, 1'b1, pk16(9, 9, 9, 9), 1'b1);
    chk("t3_hs_count", 64'(hs_count), 64'd3);

    // 4: downstream backpressure, start ignored until after the handshake
    res_ready = 1'b0;
    av[0] = pk8(10, 20, 30, 40); bv[0] = pk8(2, 2, 2, 2);
    run_job(1, 1, -1, 0, 1'b1, pk16(20, 40, 60, 80), 1'b0);
    exp_q.push_back(64'd0);
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t4_res_valid_timeout", 64'(n < 50), 64'd1);
    repeat (4) begin
      @(posedge clk); #1;
      start = 1'b1; k_len = 8'd0;
      @(negedge clk);
      chk("t4_hold_valid_busy", {62'd0, res_valid, busy}, 64'd3);
      chk("t4_hold_data", res_data, pk16(20, 40, 60, 80));
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_idle_after_hs", {62'd0, res_valid, busy}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("t4_start_next_cycle", {62'd0, res_valid, busy}, 64'd3);
    chk("t4_zero_result", res_data, 64'd0);
    wait_idle();

    // 5: zero-length job never fetches or enables the array
    @(posedge clk); #1;
    mac_en_seen = 1'b0; op_ready_seen = 1'b0;
    res_data_fill: begin
      exp_q.push_back(64'd0);
      start = 1'b1; k_len = 8'd0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("t5_res_valid", 64'(res_valid), 64'd1);
      chk("t5_res_zero", res_data, 64'd0);
    end
    wait_idle();
    chk("t5_no_mac_en_no_op_ready", {62'd0, mac_en_seen, op_ready_seen}, 64'd0);

    // 6: reset during WAIT of step 1, then a clean job
    av[0] = pk8(1, 1, 1, 1); av[1] = pk8(2, 2, 2, 2); av[2] = pk8(3, 3, 3, 3);
    bv[0] = pk8(1, 1, 1, 1); bv[1] = pk8(1, 1, 1, 1); bv[2] = pk8(1, 1, 1, 1);
    run_job(3, 2, -1, 0, 1'b0, 64'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("t6_after_reset");
    rst = 1'b0;
    av[0] = pk8(2, 3, 4, 5); bv[0] = pk8(3, 3, 3, 3);
    run_job(1, 1, -1, 0, 1'b1, pk16(6, 9, 12, 15), 1'b1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
